ahb_master_req: RTL and testbench
=================================

AHB_MASTER_REQ -- requirements
Module: ahb_master_req

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width.
REQ-002 Parameter PRIOR_BIT, default 2, priority field width.
REQ-003 Parameter UNDL_LIMIT, default 4, beat limit applied to INCR (undefined-length) bursts.
REQ-004 hclk  input  1  clock, rising edge.
REQ-005 hreset_n  input  1  asynchronous active-low reset.
REQ-006 cmd_valid  input  1  burst command offered.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid&cmd_ready.
REQ-008 cmd_addr / cmd_burst / cmd_size / cmd_write / cmd_prior  input  ADDR_WIDTH/3/3/1/PRIOR_BIT  command fields.
REQ-009 hreq  output  1  bus request to arbiter.
REQ-010 hprior  output  PRIOR_BIT  request priority.
REQ-011 hgrant  input  1  arbiter grant.
REQ-012 hready  input  1  transfer-complete/advance.
REQ-013 haddr / htrans / hburst / hsize / hwrite  output  ADDR_WIDTH/2/3/3/1  AHB address phase.
REQ-014 hlast  output  1  current address phase is final beat of burst.

Function
REQ-015 FSM states IDLE, REQ, BURST; cmd_ready=1 only in IDLE.
REQ-016 IDLE: on cmd_valid latch all cmd fields, go REQ next cycle; hreq=0, htrans=IDLE.
REQ-017 REQ: hreq=1, hprior=latched priority, htrans=IDLE; on hgrant&hready go BURST, first beat driven NONSEQ in the following cycle.
REQ-018 BURST: first beat NONSEQ, later beats SEQ; haddr/beat counter advance only when hready=1.
REQ-019 Beat count: SINGLE 1, WRAP4/INCR4 4, WRAP8/INCR8 8, WRAP16/INCR16 16, INCR UNDL_LIMIT.
REQ-020 INCR* address step = 1<<hsize; WRAPn address wraps within aligned block of n*(1<<hsize) bytes, upper bits unchanged.
REQ-021 hlast=1 exactly while the final beat's address phase is driven; deasserted otherwise.
REQ-022 Final beat accepted (hready=1, hlast=1) -> IDLE; hreq drops the same edge.
REQ-023 hreq held 1 throughout BURST until final beat accepted.
REQ-024 hgrant lost mid-burst with hready=1: go REQ, keep next address and remaining count; resume with NONSEQ, hburst=INCR.
REQ-025 hsize >3'b010 with ADDR_WIDTH arithmetic: address adds modulo 2^ADDR_WIDTH.
REQ-026 All outputs registered; cmd fields unchanged when not in IDLE.

Reset
REQ-027 hreset_n=0 asynchronously forces IDLE; hreq=0, htrans=IDLE, hlast=0, haddr=0, hburst=SINGLE, hsize=0, hwrite=0, hprior=0, cmd_ready=0 during reset, 1 first cycle after.
REQ-028 Reset mid-burst abandons the burst; no resume after release.

Configuration
REQ-029 Macro AHB_BOUNDARY_1KB_EN defined: INCR/INCRn beat whose next address crosses a 1KB boundary is marked hlast, burst ends there, remaining beats re-requested from REQ as new NONSEQ INCR burst.
REQ-030 Macro undefined: no boundary check; bursts run to full beat count.

Structure
REQ-031 hburst_type, hsize_type, htrans_type enums and beat-count constants live in AHB_package.
REQ-032 One sub-module Burst_Beat_Counter: load count, decrement on hready, flag last beat, next-address compute.

Verification
REQ-033 INCR4, addr 0x100, size WORD, hready=1, hgrant=1 -> haddr 0x100/104/108/10C, htrans NONSEQ,SEQ,SEQ,SEQ, hlast on 0x10C only.
REQ-034 WRAP4 addr 0x38 WORD -> 0x38,0x3C,0x30,0x34; hlast on 0x34.
REQ-035 INCR8 with hready=0 on beat 3 for 2 cycles -> haddr and htrans hold; total 8 beats, hlast once.
REQ-036 INCR4 at 0x200, hgrant drops after beat 2 -> REQ, resume NONSEQ at 0x208 hburst=INCR, 2 beats, hlast at 0x20C.
REQ-037 AHB_BOUNDARY_1KB_EN, INCR4 at 0x3F8 WORD -> hlast at 0x3FC, new NONSEQ at 0x400, hlast at 0x404.
REQ-038 Reset asserted mid INCR16 -> all outputs at reset values same cycle; cmd_ready=1 after release.

Source files
------------

// File: rtl/ahb_master_req_pkg.sv
// Shared AHB encodings, FSM states and burst helpers for the ahb_master_req
// request/address-phase engine.
package ahb_master_req_pkg;

    localparam int CNT_W      = 8;
    localparam int BEATS_1    = 1;
    localparam int BEATS_4    = 4;
    localparam int BEATS_8    = 8;
    localparam int BEATS_16   = 16;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_type;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_type;

    typedef enum logic [2:0] {
        HSIZE_BYTE   = 3'b000,
        HSIZE_HALF   = 3'b001,
        HSIZE_WORD   = 3'b010,
        HSIZE_DWORD  = 3'b011,
        HSIZE_4WORD  = 3'b100,
        HSIZE_8WORD  = 3'b101,
        HSIZE_16WORD = 3'b110,
        HSIZE_32WORD = 3'b111
    } hsize_type;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BURST = 2'd2
    } req_state_t;

    // Undefined-length INCR is capped at the caller-supplied limit.
    function automatic logic [CNT_W-1:0] burst_beats(input logic [2:0] burst, input int undl);
        case (hburst_type'(burst))
            HBURST_SINGLE:               return CNT_W'(BEATS_1);
            HBURST_INCR:                 return CNT_W'(undl);
            HBURST_WRAP4,  HBURST_INCR4:  return CNT_W'(BEATS_4);
            HBURST_WRAP8,  HBURST_INCR8:  return CNT_W'(BEATS_8);
            HBURST_WRAP16, HBURST_INCR16: return CNT_W'(BEATS_16);
            default:                     return CNT_W'(BEATS_1);
        endcase
    endfunction

    // Wrap block length in beats; zero means linear addressing.
    function automatic logic [4:0] wrap_beats(input logic [2:0] burst);
        case (hburst_type'(burst))
            HBURST_WRAP4:  return 5'd4;
            HBURST_WRAP8:  return 5'd8;
            HBURST_WRAP16: return 5'd16;
            default:       return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_master_req_beat_counter.sv
// Burst beat counter: remaining-beat count, current address and next-address compute.
// With AHB_BOUNDARY_1KB_EN, a linear beat whose successor crosses a 1KB boundary is flagged last.
module ahb_master_req_beat_counter
    import ahb_master_req_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  hclk,
    input  logic                  hreset_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [CNT_W-1:0]      load_cnt,
    input  logic                  advance,
    input  logic [2:0]            size,
    input  logic [4:0]            wrap_len,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [CNT_W-1:0]      cnt,
    output logic                  last_cur,
    output logic                  last_nxt
);

    logic [ADDR_WIDTH-1:0] addr_n1;

    // Linear steps add modulo 2^ADDR_WIDTH; wrapping keeps the bits above the block.
    function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [2:0] sz,
                                                        input logic [4:0] wlen);
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        inc  = a + (ADDR_WIDTH'(1) << sz);
        mask = (ADDR_WIDTH'(wlen) << sz) - ADDR_WIDTH'(1);
        if (wlen == 5'd0)
            return inc;
        return (a & ~mask) | (inc & mask);
    endfunction

    assign addr_n1 = step_addr(addr, size, wrap_len);

`ifdef AHB_BOUNDARY_1KB_EN
    logic [ADDR_WIDTH-1:0] addr_n2;

    function automatic logic crosses_1kb(input logic [ADDR_WIDTH-1:0] a,
                                         input logic [ADDR_WIDTH-1:0] b);
        return (a >> 10) != (b >> 10);
    endfunction

    assign addr_n2  = step_addr(addr_n1, size, wrap_len);
    assign last_cur = (cnt == CNT_W'(1)) || ((wrap_len == 5'd0) && crosses_1kb(addr, addr_n1));
    assign last_nxt = (cnt == CNT_W'(2)) || ((wrap_len == 5'd0) && crosses_1kb(addr_n1, addr_n2));
`else
    assign last_cur = (cnt == CNT_W'(1));
    assign last_nxt = (cnt == CNT_W'(2));
`endif

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            addr <= '0;
            cnt  <= '0;
        end else if (load) begin
            addr <= load_addr;
            cnt  <= load_cnt;
        end else if (advance) begin
            addr <= addr_n1;
            cnt  <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/ahb_master_req.sv
// AHB master request engine: takes burst commands, arbitrates for the bus and drives
// registered address phases. Optional macro AHB_BOUNDARY_1KB_EN splits INCR bursts at 1KB.
module ahb_master_req
    import ahb_master_req_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int PRIOR_BIT  = 2,
    parameter int UNDL_LIMIT = 4
) (
    input  logic                  hclk,
    input  logic                  hreset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_burst,
    input  logic [2:0]            cmd_size,
    input  logic                  cmd_write,
    input  logic [PRIOR_BIT-1:0]  cmd_prior,
    output logic                  hreq,
    output logic [PRIOR_BIT-1:0]  hprior,
    input  logic                  hgrant,
    input  logic                  hready,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic [1:0]            htrans,
    output logic [2:0]            hburst,
    output logic [2:0]            hsize,
    output logic                  hwrite,
    output logic                  hlast
);

    req_state_t       state, state_nxt;
    logic             cmd_fire;
    logic             load, advance;
    logic             hreq_nxt, hlast_nxt, cmd_ready_nxt;
    logic [1:0]       htrans_nxt;
    logic [2:0]       hburst_nxt;
    logic [4:0]       wrap_len;
    logic [CNT_W-1:0] cmd_beats;
    logic [CNT_W-1:0] cnt;
    logic             last_cur, last_nxt;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign cmd_beats = burst_beats(cmd_burst, UNDL_LIMIT);

    ahb_master_req_beat_counter #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_beat_counter (
        .hclk      (hclk),
        .hreset_n  (hreset_n),
        .load      (load),
        .load_addr (cmd_addr),
        .load_cnt  (cmd_beats),
        .advance   (advance),
        .size      (hsize),
        .wrap_len  (wrap_len),
        .addr      (haddr),
        .cnt       (cnt),
        .last_cur  (last_cur),
        .last_nxt  (last_nxt)
    );

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and next-output values; every output is registered below.
    always_comb begin
        state_nxt  = state;
        hreq_nxt   = hreq;
        htrans_nxt = htrans;
        hlast_nxt  = hlast;
        hburst_nxt = hburst;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            ST_IDLE: begin
                hreq_nxt   = 1'b0;
                htrans_nxt = HTRANS_IDLE;
                hlast_nxt  = 1'b0;
                if (cmd_fire) begin
                    load       = 1'b1;
                    hburst_nxt = cmd_burst;
                    hreq_nxt   = 1'b1;
                    state_nxt  = ST_REQ;
                end
            end
            ST_REQ: begin
                hreq_nxt   = 1'b1;
                htrans_nxt = HTRANS_IDLE;
                hlast_nxt  = 1'b0;
                if (hgrant && hready) begin
                    state_nxt  = ST_BURST;
                    htrans_nxt = HTRANS_NONSEQ;
                    hlast_nxt  = last_cur;
                end
            end
            ST_BURST: begin
                if (hready) begin
                    if (hlast && (cnt == CNT_W'(1))) begin
                        state_nxt  = ST_IDLE;
                        hreq_nxt   = 1'b0;
                        htrans_nxt = HTRANS_IDLE;
                        hlast_nxt  = 1'b0;
                    end else begin
                        advance = 1'b1;
                        if (hgrant && !hlast) begin
                            htrans_nxt = HTRANS_SEQ;
                            hlast_nxt  = last_nxt;
                        end else begin
                            // Lost grant or boundary split: re-request the remainder as INCR.
                            state_nxt  = ST_REQ;
                            htrans_nxt = HTRANS_IDLE;
                            hlast_nxt  = 1'b0;
                            hburst_nxt = HBURST_INCR;
                        end
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        cmd_ready_nxt = (state_nxt == ST_IDLE);
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            cmd_ready <= 1'b0;
            hreq      <= 1'b0;
            htrans    <= HTRANS_IDLE;
            hlast     <= 1'b0;
            hburst    <= HBURST_SINGLE;
            hsize     <= '0;
            hwrite    <= 1'b0;
            hprior    <= '0;
            wrap_len  <= '0;
        end else begin
            cmd_ready <= cmd_ready_nxt;
            hreq      <= hreq_nxt;
            htrans    <= htrans_nxt;
            hlast     <= hlast_nxt;
            hburst    <= hburst_nxt;
            if (load) begin
                hsize    <= cmd_size;
                hwrite   <= cmd_write;
                hprior   <= cmd_prior;
                wrap_len <= wrap_beats(cmd_burst);
            end
        end
    end

endmodule

// File: tb/tb_ahb_master_req.sv
// Directed bench for ahb_master_req: burst address sequences, stalls, grant loss,
// 1KB split (when AHB_BOUNDARY_1KB_EN is defined) and reset behaviour.
`timescale 1ns/1ps
module tb_ahb_master_req;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0;
    localparam logic [2:0] B_INCR   = 3'd1;
    localparam logic [2:0] B_WRAP4  = 3'd2;
    localparam logic [2:0] B_INCR4  = 3'd3;
    localparam logic [2:0] B_WRAP8  = 3'd4;
    localparam logic [2:0] B_INCR8  = 3'd5;
    localparam logic [2:0] B_INCR16 = 3'd7;

    logic        hclk;
    logic        hreset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_burst;
    logic [2:0]  cmd_size;
    logic        cmd_write;
    logic [1:0]  cmd_prior;
    logic        hreq;
    logic [1:0]  hprior;
    logic        hgrant;
    logic        hready;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic        hwrite;
    logic        hlast;

    int n_tests = 0;
    int n_fail  = 0;
    int n_last  = 0;

    logic [31:0] b_addr[$];
    logic [1:0]  b_trans[$];
    logic        b_last[$];
    logic [2:0]  b_burst[$];
    logic [31:0] s_addr[$];
    logic [1:0]  s_trans[$];
    logic [31:0] e_addr[$];
    logic [1:0]  e_trans[$];
    logic        e_last[$];

    ahb_master_req dut (
        .hclk      (hclk),
        .hreset_n  (hreset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_burst (cmd_burst),
        .cmd_size  (cmd_size),
        .cmd_write (cmd_write),
        .cmd_prior (cmd_prior),
        .hreq      (hreq),
        .hprior    (hprior),
        .hgrant    (hgrant),
        .hready    (hready),
        .haddr     (haddr),
        .htrans    (htrans),
        .hburst    (hburst),
        .hsize     (hsize),
        .hwrite    (hwrite),
        .hlast     (hlast)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
        chk({tag, "_hreq"},      64'(hreq),      64'd0);
        chk({tag, "_htrans"},    64'(htrans),    64'(T_IDLE));
        chk({tag, "_hlast"},     64'(hlast),     64'd0);
        chk({tag, "_haddr"},     64'(haddr),     64'd0);
        chk({tag, "_hburst"},    64'(hburst),    64'(B_SINGLE));
        chk({tag, "_hsize"},     64'(hsize),     64'd0);
        chk({tag, "_hwrite"},    64'(hwrite),    64'd0);
        chk({tag, "_hprior"},    64'(hprior),    64'd0);
    endtask

    task automatic issue_cmd(input logic [31:0] a, input logic [2:0] b, input logic [2:0] s,
                             input logic w, input logic [1:0] p);
        int waited = 0;
        while (!cmd_ready && waited < 20) begin
            @(posedge hclk); #1;
            waited++;
        end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_burst = b;
        cmd_size  = s;
        cmd_write = w;
        cmd_prior = p;
        @(posedge hclk); #1;
        cmd_valid = 1'b0;
        chk("req_hreq",      64'(hreq),      64'd1);
        chk("req_htrans",    64'(htrans),    64'(T_IDLE));
        chk("req_hprior",    64'(hprior),    64'(p));
        chk("req_cmd_ready", 64'(cmd_ready), 64'd0);
    endtask

    // Plays arbiter/slave until the master returns to idle, logging every accepted beat.
    task automatic run_burst(input int stall_beat, input int stall_len, input int drop_beat);
        int stalled = 0;
        bit done = 1'b0;
        b_addr.delete(); b_trans.delete(); b_last.delete(); b_burst.delete();
        s_addr.delete(); s_trans.delete();
        n_last = 0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            hgrant = 1'b1;
            hready = 1'b1;
            if (htrans == T_NONSEQ || htrans == T_SEQ) begin
                if (b_addr.size() == stall_beat && stalled < stall_len) begin
                    hready = 1'b0;
                    stalled++;
                    s_addr.push_back(haddr);
                    s_trans.push_back(htrans);
                end else begin
                    if (b_addr.size() == drop_beat)
                        hgrant = 1'b0;
                    b_addr.push_back(haddr);
                    b_trans.push_back(htrans);
                    b_last.push_back(hlast);
                    b_burst.push_back(hburst);
                    if (hlast) n_last++;
                end
            end else if (hlast) begin
                chk("hlast_while_idle", 64'(hlast), 64'd0);
            end
            @(posedge hclk); #1;
            if (cmd_ready) done = 1'b1;
        end
        chk("burst_done",  64'(done),   64'd1);
        chk("idle_hreq",   64'(hreq),   64'd0);
        chk("idle_htrans", 64'(htrans), 64'(T_IDLE));
        chk("idle_hlast",  64'(hlast),  64'd0);
    endtask

    task automatic verify_beats(input string tag);
        chk({tag, "_nbeats"}, 64'(b_addr.size()), 64'(e_addr.size()));
        for (int i = 0; i < e_addr.size(); i++) begin
            if (i < b_addr.size()) begin
                chk($sformatf("%s_addr%0d", tag, i),  64'(b_addr[i]),  64'(e_addr[i]));
                chk($sformatf("%s_trans%0d", tag, i), 64'(b_trans[i]), 64'(e_trans[i]));
                chk($sformatf("%s_last%0d", tag, i),  64'(b_last[i]),  64'(e_last[i]));
            end
        end
    endtask

    initial begin
        hreset_n  = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_burst = '0;
        cmd_size  = '0;
        cmd_write = 1'b0;
        cmd_prior = '0;
        hgrant    = 1'b0;
        hready    = 1'b1;

        repeat (2) @(posedge hclk);
        #1;
        check_reset_outputs("rst");
        hreset_n = 1'b1;
        @(posedge hclk); #1;
        chk("rst_release_cmd_ready", 64'(cmd_ready), 64'd1);

        // INCR4 word at 0x100
        issue_cmd(32'h100, B_INCR4, 3'd2, 1'b1, 2'd2);
        run_burst(-1, 0, -1);
        e_addr  = '{32'h100, 32'h104, 32'h108, 32'h10C};
        e_trans = '{T_NONSEQ, T_SEQ, T_SEQ, T_SEQ};
        e_last  = '{1'b0, 1'b0, 1'b0, 1'b1};
        verify_beats("incr4");
        chk("incr4_hburst", 64'(b_burst[0]), 64'(B_INCR4));
        chk("incr4_hsize",  64'(hsize),      64'd2);
        chk("incr4_hwrite", 64'(hwrite),     64'd1);

        // WRAP4 word at 0x38
        issue_cmd(32'h38, B_WRAP4, 3'd2, 1'b0, 2'd1);
        run_burst(-1, 0, -1);
        e_addr  = '{32'h38, 32'h3C, 32'h30, 32'h34};
        e_trans = '{T_NONSEQ, T_SEQ, T_SEQ, T_SEQ};
        e_last  = '{1'b0, 1'b0, 1'b0, 1'b1};
        verify_beats("wrap4");

        // WRAP8 word at 0x74 wraps inside the 32-byte block at 0x60
        issue_cmd(32'h74, B_WRAP8, 3'd2, 1'b0, 2'd0);
        run_burst(-1, 0, -1);
        e_addr  = '{32'h74, 32'h78, 32'h7C, 32'h60, 32'h64, 32'h68, 32'h6C, 32'h70};
        e_trans = '{T_NONSEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ};
        e_last  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        verify_beats("wrap8");

        // INCR8 with two wait states on the third beat
        issue_cmd(32'h40, B_INCR8, 3'd2, 1'b1, 2'd3);
        run_burst(2, 2, -1);
        e_addr  = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h58, 32'h5C};
        e_trans = '{T_NONSEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ};
        e_last  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        verify_beats("stall");
        chk("stall_nwait",   64'(s_addr.size()), 64'd2);
        chk("stall_addr0",   64'(s_addr[0]),     64'h48);
        chk("stall_addr1",   64'(s_addr[1]),     64'h48);
        chk("stall_trans1",  64'(s_trans[1]),    64'(T_SEQ));
        chk("stall_n_hlast", 64'(n_last),        64'd1);

        // INCR4 at 0x200 losing grant after the second beat
        issue_cmd(32'h200, B_INCR4, 3'd2, 1'b0, 2'd1);
        run_burst(-1, 0, 1);
        e_addr  = '{32'h200, 32'h204, 32'h208, 32'h20C};
        e_trans = '{T_NONSEQ, T_SEQ, T_NONSEQ, T_SEQ};
        e_last  = '{1'b0, 1'b0, 1'b0, 1'b1};
        verify_beats("regrant");
        chk("regrant_hburst_first",  64'(b_burst[0]), 64'(B_INCR4));
        chk("regrant_hburst_resume", 64'(b_burst[2]), 64'(B_INCR));

        // Undefined-length INCR capped at four byte beats
        issue_cmd(32'h10, B_INCR, 3'd0, 1'b0, 2'd0);
        run_burst(-1, 0, -1);
        e_addr  = '{32'h10, 32'h11, 32'h12, 32'h13};
        e_trans = '{T_NONSEQ, T_SEQ, T_SEQ, T_SEQ};
        e_last  = '{1'b0, 1'b0, 1'b0, 1'b1};
        verify_beats("undl");

        // SINGLE halfword
        issue_cmd(32'h80, B_SINGLE, 3'd1, 1'b1, 2'd0);
        run_burst(-1, 0, -1);
        e_addr  = '{32'h80};
        e_trans = '{T_NONSEQ};
        e_last  = '{1'b1};
        verify_beats("single");

`ifdef AHB_BOUNDARY_1KB_EN
        // INCR4 at 0x3F8 splits at the 1KB line
        issue_cmd(32'h3F8, B_INCR4, 3'd2, 1'b0, 2'd0);
        run_burst(-1, 0, -1);
        e_addr  = '{32'h3F8, 32'h3FC, 32'h400, 32'h404};
        e_trans = '{T_NONSEQ, T_SEQ, T_NONSEQ, T_SEQ};
        e_last  = '{1'b0, 1'b1, 1'b0, 1'b1};
        verify_beats("kb_split");
        chk("kb_split_hburst", 64'(b_burst[2]), 64'(B_INCR));
        chk("kb_split_n_hlast", 64'(n_last), 64'd2);
`else
        // Without the boundary option the same burst runs straight through
        issue_cmd(32'h3F8, B_INCR4, 3'd2, 1'b0, 2'd0);
        run_burst(-1, 0, -1);
        e_addr  = '{32'h3F8, 32'h3FC, 32'h400, 32'h404};
        e_trans = '{T_NONSEQ, T_SEQ, T_SEQ, T_SEQ};
        e_last  = '{1'b0, 1'b0, 1'b0, 1'b1};
        verify_beats("kb_through");

        // Address wraps modulo 2^32
        issue_cmd(32'hFFFF_FFF8, B_INCR4, 3'd2, 1'b0, 2'd0);
        run_burst(-1, 0, -1);
        e_addr  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        e_trans = '{T_NONSEQ, T_SEQ, T_SEQ, T_SEQ};
        e_last  = '{1'b0, 1'b0, 1'b0, 1'b1};
        verify_beats("modulo");
`endif

        // Reset in the middle of an INCR16
        issue_cmd(32'h1000, B_INCR16, 3'd2, 1'b1, 2'd3);
        hgrant = 1'b1;
        hready = 1'b1;
        repeat (3) @(posedge hclk);
        #1;
        chk("r16_haddr_pre",  64'(haddr),  64'h1008);
        chk("r16_htrans_pre", 64'(htrans), 64'(T_SEQ));
        chk("r16_hreq_pre",   64'(hreq),   64'd1);
        #2 hreset_n = 1'b0;
        #1;
        check_reset_outputs("r16_async");
        @(posedge hclk); #1;
        hreset_n = 1'b1;
        @(posedge hclk); #1;
        chk("r16_cmd_ready_after", 64'(cmd_ready), 64'd1);
        repeat (3) @(posedge hclk);
        #1;
        chk("r16_no_resume_hreq",   64'(hreq),   64'd0);
        chk("r16_no_resume_htrans", 64'(htrans), 64'(T_IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
